// File: rtl/samp_play_ctl.sv
// Sample playback controller: paces sample-RAM reads, hands samples to the DAC
// driver over valid/ready, and shares the single RAM port with the command path.
//
// state | meaning
// IDLE  | stopped; waits for en, latches config on start
// FETCH | playback owns the RAM port, read issued for the current index
// LOAD  | RAM data returns, captured into the DAC output register
// RUN   | waiting for the next sample event
module samp_play_ctl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W:0]   nsamp,
    input  logic [CNT_W-1:0]  prescale,
    input  logic [CNT_W-1:0]  speed,
    input  logic              cmd_req,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_gnt,
    output logic              cmd_rvalid,
    output logic [DATA_W-1:0] cmd_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dac_valid,
    output logic [DATA_W-1:0] dac_data,
    input  logic              dac_ready,
    output logic              active,
    output logic              underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]  NSAMP_ONE = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     nsamp_q, nsamp_d;
    logic [CNT_W-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0]    spd_q, spd_d;
    logic [CNT_W-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic                underrun_q, underrun_d;
    logic                dac_valid_q, dac_valid_d;
    logic [DATA_W-1:0]   dac_data_q, dac_data_d;
    logic                cmd_rvalid_q, cmd_rvalid_d;

    logic [ADDR_W:0]     nsamp_c;
    logic [CNT_W-1:0]    pre_c;
    logic [CNT_W-1:0]    spd_c;
    logic                tick;
    logic                evt;

    function automatic logic [ADDR_W-1:0] idx_inc(input logic [ADDR_W-1:0] idx,
                                                   input logic [ADDR_W:0]   n);
        logic [ADDR_W-1:0] nxt;
        if ({1'b0, idx} == n - NSAMP_ONE) nxt = '0;
        else                              nxt = idx + ADDR_W'(1);
        return nxt;
    endfunction

    // Zero config values are clamped to 1; a 1x1 rate is stretched to the
    // 2-clock minimum by running the prescaler at 2.
    always_comb begin
        nsamp_c = (nsamp == '0) ? NSAMP_ONE : nsamp;
        pre_c   = (prescale == '0) ? CNT_ONE : prescale;
        spd_c   = (speed == '0) ? CNT_ONE : speed;
        if (pre_c == CNT_ONE && spd_c == CNT_ONE) pre_c = CNT_TWO;
    end

    assign tick = (pcnt_q == '0);
    assign evt  = tick && (scnt_q == '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nsamp_d     = nsamp_q;
        pre_d       = pre_q;
        spd_d       = spd_q;
        pcnt_d      = pcnt_q;
        scnt_d      = scnt_q;
        underrun_d  = underrun_q;
        dac_valid_d = dac_valid_q & ~dac_ready;
        dac_data_d  = dac_data_q;

        // Down-counters wrap to their tops on a sample event, which is exactly
        // the restart value needed in the following FETCH cycle.
        if (state_q != ST_IDLE) begin
            if (tick) begin
                pcnt_d = pre_q - CNT_ONE;
                scnt_d = (scnt_q == '0) ? spd_q - CNT_ONE : scnt_q - CNT_ONE;
            end else begin
                pcnt_d = pcnt_q - CNT_ONE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    nsamp_d    = nsamp_c;
                    pre_d      = pre_c;
                    spd_d      = spd_c;
                    idx_d      = '0;
                    pcnt_d     = pre_c - CNT_ONE;
                    scnt_d     = spd_c - CNT_ONE;
                    underrun_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dac_valid_d = 1'b1;
                dac_data_d  = ram_rdata;
                idx_d       = idx_inc(idx_q, nsamp_q);
                // A previous sample still pending here is overwritten: count it as dropped.
                if (dac_valid_q && !dac_ready) underrun_d = 1'b1;
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (evt && dac_valid_q) begin
                    underrun_d = 1'b1;
                    idx_d      = idx_inc(idx_inc(idx_q, nsamp_q), nsamp_q);
                    state_d    = ST_RUN;
                end else if (evt) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (evt && dac_valid_q) begin
                    underrun_d = 1'b1;
                    idx_d      = idx_inc(idx_q, nsamp_q);
                end else if (evt) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_gnt      = cmd_req & (state_q != ST_FETCH);
    assign cmd_rvalid_d = cmd_gnt & ~cmd_we;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == ST_FETCH) begin
            ram_en   = 1'b1;
            ram_addr = idx_q;
        end else if (cmd_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cmd_we;
            ram_addr  = cmd_addr;
            ram_wdata = cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            nsamp_q      <= '0;
            pre_q        <= '0;
            spd_q        <= '0;
            pcnt_q       <= '0;
            scnt_q       <= '0;
            underrun_q   <= 1'b0;
            dac_valid_q  <= 1'b0;
            dac_data_q   <= '0;
            cmd_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            nsamp_q      <= nsamp_d;
            pre_q        <= pre_d;
            spd_q        <= spd_d;
            pcnt_q       <= pcnt_d;
            scnt_q       <= scnt_d;
            underrun_q   <= underrun_d;
            dac_valid_q  <= dac_valid_d;
            dac_data_q   <= dac_data_d;
            cmd_rvalid_q <= cmd_rvalid_d;
        end
    end

    // The RAM has one clock of read latency, so read data is visible directly
    // in the cycle after the grant.
    assign cmd_rvalid = cmd_rvalid_q;
    assign cmd_rdata  = cmd_rvalid_q ? ram_rdata : '0;
    assign dac_valid  = dac_valid_q;
    assign dac_data   = dac_data_q;
    assign active     = (state_q != ST_IDLE);
    assign underrun   = underrun_q;

endmodule
